// File: rtl/beep_pkg.sv
// Shared types and widths for the beep arbiter and its tone divider.
package beep_pkg;

  localparam int unsigned N_REQ  = 3;
  localparam int unsigned TONE_W = 18;
  localparam int unsigned DUR_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } beep_state_e;

  // Isolates the lowest set bit; index 0 is the highest priority.
  function automatic logic [N_REQ-1:0] lowest_onehot(input logic [N_REQ-1:0] v);
    return v & (~v + N_REQ'(1));
  endfunction

endpackage

// File: rtl/beep_tone_div.sv
// Square-wave tone divider: toggles the output every half_i cycles while enabled.
module beep_tone_div
  import beep_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              restart_i,
  input  logic              en_i,
  input  logic              mute_i,
  input  logic [TONE_W-1:0] half_i,
  output logic              sound_o
);

  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              snd_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_i || !en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == half_i - TONE_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + TONE_W'(1);
    end
  end

  // Mute only gates the driven output; the phase keeps running underneath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      snd_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      snd_q   <= phase_d & ~mute_i;
    end
  end

  assign sound_o = snd_q;

endmodule

// File: rtl/beep_arbiter.sv
// Fixed-priority beep arbiter: queues requests, plays one beep then a silent gap.
// Define BEEP_PREEMPT_EN to let a higher-priority request interrupt a beep in PLAY.
module beep_arbiter
  import beep_pkg::*;
#(
  parameter int unsigned HALF0 = 65536,
  parameter int unsigned HALF1 = 98304,
  parameter int unsigned HALF2 = 131072,
  parameter int unsigned DUR   = 4194304,
  parameter int unsigned GAP   = 2097152
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [N_REQ-1:0] iREQ,
  input  logic             iMUTE,
  output logic             oSOUND,
  output logic [N_REQ-1:0] oGNT,
  output logic             oBUSY,
  output logic [N_REQ-1:0] oDONE
);

  beep_state_e       state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;

  logic [N_REQ-1:0]  pick;
  logic [N_REQ-1:0]  clr_mask;
  logic [N_REQ-1:0]  requeue_mask;
  logic              restart;
  logic [TONE_W-1:0] half_sel;

  // One counter serves both the beep duration and the gap length.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    done_d       = '0;
    clr_mask     = '0;
    requeue_mask = '0;
    restart      = 1'b0;
    pick         = lowest_onehot(pend_q);

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q != '0) begin
          state_d  = ST_PLAY;
          gnt_d    = pick;
          clr_mask = pick;
          cnt_d    = '0;
          restart  = 1'b1;
        end
      end
      ST_PLAY: begin
`ifdef BEEP_PREEMPT_EN
        if ((pend_q & (gnt_q - N_REQ'(1))) != '0) begin
          gnt_d        = pick;
          clr_mask     = pick;
          requeue_mask = gnt_q;
          cnt_d        = '0;
          restart      = 1'b1;
        end else
`endif
        if (cnt_q == DUR_W'(DUR - 1)) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          cnt_d   = '0;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + DUR_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == DUR_W'(GAP - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DUR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // A new request on the clearing edge wins over the clear.
    pend_d = (pend_q & ~clr_mask) | requeue_mask | iREQ;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  always_comb begin
    half_sel = TONE_W'(HALF0);
    if (gnt_q[1]) begin
      half_sel = TONE_W'(HALF1);
    end else if (gnt_q[2]) begin
      half_sel = TONE_W'(HALF2);
    end
  end

  beep_tone_div u_tone (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .restart_i (restart),
    .en_i      (state_d == ST_PLAY),
    .mute_i    (iMUTE),
    .half_i    (half_sel),
    .sound_o   (oSOUND)
  );

  assign oGNT  = gnt_q;
  assign oBUSY = busy_q;
  assign oDONE = done_q;

endmodule

// File: tb/tb_beep_arbiter.sv
// Bench for beep_arbiter: schedule-based reference model plus directed scenarios.
module tb_beep_arbiter;

  localparam int unsigned H0 = 4;
  localparam int unsigned H1 = 6;
  localparam int unsigned H2 = 8;
  localparam int unsigned D  = 40;
  localparam int unsigned G  = 10;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iMUTE;
  logic [2:0] iREQ;
  logic       oSOUND;
  logic [2:0] oGNT;
  logic       oBUSY;
  logic [2:0] oDONE;

  beep_arbiter #(
    .HALF0 (H0),
    .HALF1 (H1),
    .HALF2 (H2),
    .DUR   (D),
    .GAP   (G)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iREQ   (iREQ),
    .iMUTE  (iMUTE),
    .oSOUND (oSOUND),
    .oGNT   (oGNT),
    .oBUSY  (oBUSY),
    .oDONE  (oDONE)
  );

  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  // Model: a beep is described by its start cycle and requester.
  int         t     = 0;
  bit         valid = 1'b0;
  bit         act   = 1'b0;
  int         st    = 0;
  int         r     = 0;
  logic [2:0] mpend = 3'b000;
  bit         mmute = 1'b0;

  int   gnt_cnt = 0, done_cnt = 0, done2_cnt = 0, rise_cnt = 0, busy_cnt = 0;
  logic prev_snd = 1'b0;

  function automatic int half_of(input int i);
    if (i == 0) return H0;
    if (i == 1) return H1;
    return H2;
  endfunction

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", nm, got, want, t);
    end
  endtask

  task automatic model_step(input logic [2:0] req, input logic rst, input logic mute);
    int  prv;
    bit  idle_prev;
    bit  play_prev;
    int  nr;
    t++;
    mmute = mute;
    if (rst) begin
      mpend = 3'b000;
      act   = 1'b0;
      valid = 1'b1;
      return;
    end
    prv       = t - 1;
    idle_prev = !act || (prv >= st + int'(D + G));
    play_prev = act && (prv < st + int'(D));
    if (idle_prev && mpend != 3'b000) begin
      nr        = lowest(mpend);
      mpend[nr] = 1'b0;
      act       = 1'b1;
      st        = t;
      r         = nr;
    end
`ifdef BEEP_PREEMPT_EN
    else if (play_prev && lowest(mpend) < r) begin
      nr        = lowest(mpend);
      mpend[nr] = 1'b0;
      mpend[r]  = 1'b1;
      r         = nr;
      st        = t;
    end
`endif
    mpend = mpend | req;
  endtask

  always @(posedge iCLK) begin
    logic [2:0] egnt, edone;
    logic       esnd, ebusy;
    bit         in_play;
    model_step(iREQ, iRST, iMUTE);
    #1;
    if (valid) begin
      in_play = act && (t >= st) && (t < st + int'(D));
      egnt    = in_play ? 3'(1 << r) : 3'b000;
      esnd    = in_play && ((((t - st) / half_of(r)) % 2) == 1) && !mmute;
      edone   = (act && t == st + int'(D)) ? 3'(1 << r) : 3'b000;
      ebusy   = act && (t < st + int'(D + G));
      chk("gnt",   32'(oGNT),   32'(egnt));
      chk("sound", 32'(oSOUND), 32'(esnd));
      chk("done",  32'(oDONE),  32'(edone));
      chk("busy",  32'(oBUSY),  32'(ebusy));
      if (oGNT != 3'b000) gnt_cnt++;
      if (oDONE != 3'b000) done_cnt++;
      if (oDONE[2]) done2_cnt++;
      if (oBUSY) busy_cnt++;
      if (oSOUND && !prev_snd) rise_cnt++;
      prev_snd = oSOUND;
    end
  end

  task automatic clr_stats();
    gnt_cnt = 0; done_cnt = 0; done2_cnt = 0; rise_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic pulse(input logic [2:0] v);
    iREQ = v;
    @(negedge iCLK);
    iREQ = 3'b000;
  endtask

  initial begin
    iRST  = 1'b1;
    iREQ  = 3'b000;
    iMUTE = 1'b0;
    wait_cyc(3);
    iRST = 1'b0;
    chk("rst_gnt",  32'(oGNT),  32'd0);
    chk("rst_busy", 32'(oBUSY), 32'd0);
    wait_cyc(2);

    // Single request
    clr_stats();
    pulse(3'b001);
    wait_cyc(70);
    chk("single_gnt_cycles",  gnt_cnt,  40);
    chk("single_done_pulses", done_cnt, 1);
    chk("single_rises",       rise_cnt, 5);
    chk("single_busy_cycles", busy_cnt, 50);

    // All three at once, served 0,1,2
    clr_stats();
    pulse(3'b111);
    wait_cyc(175);
    chk("all_gnt_cycles",  gnt_cnt,  120);
    chk("all_done_pulses", done_cnt, 3);
    chk("all_rises",       rise_cnt, 10);
    chk("all_busy_cycles", busy_cnt, 150);

    // Requester 2 re-requests at its PLAY cycle 20
    clr_stats();
    pulse(3'b100);
    wait_cyc(21);
    pulse(3'b100);
    wait_cyc(120);
    chk("rereq_gnt_cycles",  gnt_cnt,   80);
    chk("rereq_done2",       done2_cnt, 2);
    chk("rereq_busy_cycles", busy_cnt,  100);

    // Muted beep
    clr_stats();
    iMUTE = 1'b1;
    pulse(3'b001);
    wait_cyc(70);
    iMUTE = 1'b0;
    chk("mute_rises",       rise_cnt, 0);
    chk("mute_gnt_cycles",  gnt_cnt,  40);
    chk("mute_done_pulses", done_cnt, 1);
    chk("mute_busy_cycles", busy_cnt, 50);

    // Reset at PLAY cycle 15 with requester 1 still queued
    clr_stats();
    pulse(3'b011);
    wait_cyc(16);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    chk("rstmid_gnt",   32'(oGNT),   32'd0);
    chk("rstmid_busy",  32'(oBUSY),  32'd0);
    chk("rstmid_sound", 32'(oSOUND), 32'd0);
    chk("rstmid_done",  done_cnt,    0);
    clr_stats();
    wait_cyc(100);
    chk("rstmid_later_gnt",  gnt_cnt,  0);
    chk("rstmid_later_busy", busy_cnt, 0);
    chk("rstmid_later_done", done_cnt, 0);

    // Requester 0 arrives at PLAY cycle 10 of requester 2
    clr_stats();
    pulse(3'b100);
    wait_cyc(11);
    pulse(3'b001);
    wait_cyc(200);
    chk("pre_done_pulses", done_cnt,  2);
    chk("pre_done2",       done2_cnt, 1);
`ifdef BEEP_PREEMPT_EN
    chk("pre_gnt_cycles",  gnt_cnt,   92);
`else
    chk("pre_gnt_cycles",  gnt_cnt,   80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
